cc_decoder_read_port: RTL and testbench

Parametrised, registered dual-port read selector for the micro-datapath register bank. Every cycle it can accept one read request carrying two channel selections (A and B). It returns both selected words one cycle later through a valid/ready handshake. A write-forwarding path returns the word being written in the same cycle, so a read never sees stale data. It sits between the register bank outputs and the ALU operand latches, and replaces the fixed 38-way combinational read decoder.

---
 rtl/cc_decoder_read_port_if.sv | 44 ++++
 rtl/cc_decoder_read_port.sv | 101 ++++++++++
 tb/tb_cc_decoder_read_port.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/cc_decoder_read_port_if.sv
// Request/response bundle for the register-bank read port: channel words, two
// selections, the write-forward path and the valid/ready handshakes on both sides.
interface cc_decoder_read_port_if #(
  parameter int DATAWIDTH_BUS           = 32,
  parameter int NUM_CHANNELS            = 38,
  parameter int DATAWIDTH_MUX_SELECTION = 6
);
  logic [NUM_CHANNELS*DATAWIDTH_BUS-1:0] CC_DECODER_READ_PORT_DataBUS_In;
  logic [DATAWIDTH_MUX_SELECTION-1:0]    CC_DECODER_READ_PORT_SelA_In;
  logic [DATAWIDTH_MUX_SELECTION-1:0]    CC_DECODER_READ_PORT_SelB_In;
  logic                                  CC_DECODER_READ_PORT_ReqValid_In;
  logic                                  CC_DECODER_READ_PORT_ReqReady_Out;
  logic                                  CC_DECODER_READ_PORT_WrEnable_In;
  logic [DATAWIDTH_MUX_SELECTION-1:0]    CC_DECODER_READ_PORT_WrSel_In;
  logic [DATAWIDTH_BUS-1:0]              CC_DECODER_READ_PORT_WrData_In;
  logic [DATAWIDTH_BUS-1:0]              CC_DECODER_READ_PORT_DataA_Out;
  logic [DATAWIDTH_BUS-1:0]              CC_DECODER_READ_PORT_DataB_Out;
  logic                                  CC_DECODER_READ_PORT_ErrA_Out;
  logic                                  CC_DECODER_READ_PORT_ErrB_Out;
  logic                                  CC_DECODER_READ_PORT_OutValid_Out;
  logic                                  CC_DECODER_READ_PORT_OutReady_In;

  // Requester / consumer side.
  modport master (
    output CC_DECODER_READ_PORT_DataBUS_In, CC_DECODER_READ_PORT_SelA_In,
           CC_DECODER_READ_PORT_SelB_In, CC_DECODER_READ_PORT_ReqValid_In,
           CC_DECODER_READ_PORT_WrEnable_In, CC_DECODER_READ_PORT_WrSel_In,
           CC_DECODER_READ_PORT_WrData_In, CC_DECODER_READ_PORT_OutReady_In,
    input  CC_DECODER_READ_PORT_ReqReady_Out, CC_DECODER_READ_PORT_DataA_Out,
           CC_DECODER_READ_PORT_DataB_Out, CC_DECODER_READ_PORT_ErrA_Out,
           CC_DECODER_READ_PORT_ErrB_Out, CC_DECODER_READ_PORT_OutValid_Out
  );

  // Read-port side.
  modport slave (
    input  CC_DECODER_READ_PORT_DataBUS_In, CC_DECODER_READ_PORT_SelA_In,
           CC_DECODER_READ_PORT_SelB_In, CC_DECODER_READ_PORT_ReqValid_In,
           CC_DECODER_READ_PORT_WrEnable_In, CC_DECODER_READ_PORT_WrSel_In,
           CC_DECODER_READ_PORT_WrData_In, CC_DECODER_READ_PORT_OutReady_In,
    output CC_DECODER_READ_PORT_ReqReady_Out, CC_DECODER_READ_PORT_DataA_Out,
           CC_DECODER_READ_PORT_DataB_Out, CC_DECODER_READ_PORT_ErrA_Out,
           CC_DECODER_READ_PORT_ErrB_Out, CC_DECODER_READ_PORT_OutValid_Out
  );
endinterface

// File: rtl/cc_decoder_read_port.sv
// Registered dual-port channel selector with write forwarding and a single-entry
// valid/ready output stage; replaces the fixed combinational read decoder.
module cc_decoder_read_port #(
  parameter int DATAWIDTH_BUS           = 32,
  parameter int NUM_CHANNELS            = 38,
  parameter int DATAWIDTH_MUX_SELECTION = 6,
  parameter bit ZERO_CHANNEL0           = 1'b0
) (
  input logic                   CC_DECODER_READ_PORT_CLOCK_50,
  input logic                   CC_DECODER_READ_PORT_RESET_InHigh,
  cc_decoder_read_port_if.slave bus
);
  typedef logic [DATAWIDTH_BUS-1:0]           wordType;
  typedef logic [DATAWIDTH_MUX_SELECTION-1:0] selType;
  typedef logic [NUM_CHANNELS*DATAWIDTH_BUS-1:0] busType;

  typedef struct packed {
    wordType word;
    logic    err;
  } readResultType;

  typedef enum logic { EMPTY, FULL } stateType;

  stateType      stateReg, stateNext;
  readResultType resultA, resultB, regA, regB;
  logic          reqReady, accept;

  // Priority: out-of-range, hard-wired zero channel, same-cycle write, bank word.
  function automatic readResultType resolveRead(
    input selType  sel,
    input busType  dataBus,
    input logic    wrEnable,
    input selType  wrSel,
    input wordType wrData
  );
    readResultType res;
    res = '0;
    if (int'(sel) >= NUM_CHANNELS) begin
      res.word = ZERO_CHANNEL0 ? '0 : dataBus[DATAWIDTH_BUS-1:0];
      res.err  = 1'b1;
    end else if (ZERO_CHANNEL0 && (sel == '0)) begin
      res.word = '0;
    end else if (wrEnable && (int'(wrSel) < NUM_CHANNELS) && (wrSel == sel)) begin
      res.word = wrData;
    end else begin
      res.word = dataBus[int'(sel)*DATAWIDTH_BUS +: DATAWIDTH_BUS];
    end
    return res;
  endfunction

  assign resultA = resolveRead(bus.CC_DECODER_READ_PORT_SelA_In,
                               bus.CC_DECODER_READ_PORT_DataBUS_In,
                               bus.CC_DECODER_READ_PORT_WrEnable_In,
                               bus.CC_DECODER_READ_PORT_WrSel_In,
                               bus.CC_DECODER_READ_PORT_WrData_In);
  assign resultB = resolveRead(bus.CC_DECODER_READ_PORT_SelB_In,
                               bus.CC_DECODER_READ_PORT_DataBUS_In,
                               bus.CC_DECODER_READ_PORT_WrEnable_In,
                               bus.CC_DECODER_READ_PORT_WrSel_In,
                               bus.CC_DECODER_READ_PORT_WrData_In);

  // Ready depends only on the stage and the consumer, never on the requester.
  assign reqReady = (stateReg == EMPTY) || bus.CC_DECODER_READ_PORT_OutReady_In;
  assign accept   = bus.CC_DECODER_READ_PORT_ReqValid_In && reqReady;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      EMPTY:   if (accept) stateNext = FULL;
      FULL: begin
        if (accept)                                    stateNext = FULL;
        else if (bus.CC_DECODER_READ_PORT_OutReady_In) stateNext = EMPTY;
      end
      default: stateNext = EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  // NOTE: the result registers are ordinary flops, not a memory, so they are cleared with the stage.
  always_ff @(posedge CC_DECODER_READ_PORT_CLOCK_50) begin
    if (CC_DECODER_READ_PORT_RESET_InHigh) begin
      stateReg <= EMPTY;
      regA     <= '0;
      regB     <= '0;
    end else begin
      stateReg <= stateNext;
      if (accept) begin
        regA <= resultA;
        regB <= resultB;
      end
    end
  end

  assign bus.CC_DECODER_READ_PORT_ReqReady_Out = reqReady;
  assign bus.CC_DECODER_READ_PORT_OutValid_Out = (stateReg == FULL);
  assign bus.CC_DECODER_READ_PORT_DataA_Out    = regA.word;
  assign bus.CC_DECODER_READ_PORT_DataB_Out    = regB.word;
  assign bus.CC_DECODER_READ_PORT_ErrA_Out     = regA.err;
  assign bus.CC_DECODER_READ_PORT_ErrB_Out     = regB.err;
endmodule

// File: tb/tb_cc_decoder_read_port.sv
// Directed bench for cc_decoder_read_port: a plain instance and a ZERO_CHANNEL0 instance
// share one stimulus; table vectors plus hand sequences for backpressure and reset.
module tb_cc_decoder_read_port;
  localparam int W = 32;
  localparam int N = 38;
  localparam int S = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N*W-1:0] dataBus;
  logic [S-1:0]   selA, selB, wrSel;
  logic [W-1:0]   wrData;
  logic           reqValid, wrEnable, outReady;

  cc_decoder_read_port_if #(.DATAWIDTH_BUS(W), .NUM_CHANNELS(N), .DATAWIDTH_MUX_SELECTION(S)) normalBus ();
  cc_decoder_read_port_if #(.DATAWIDTH_BUS(W), .NUM_CHANNELS(N), .DATAWIDTH_MUX_SELECTION(S)) zeroBus ();

  cc_decoder_read_port #(.DATAWIDTH_BUS(W), .NUM_CHANNELS(N), .DATAWIDTH_MUX_SELECTION(S),
                         .ZERO_CHANNEL0(1'b0)) dutNormal (
    .CC_DECODER_READ_PORT_CLOCK_50    (clk),
    .CC_DECODER_READ_PORT_RESET_InHigh(rst),
    .bus                              (normalBus)
  );
  cc_decoder_read_port #(.DATAWIDTH_BUS(W), .NUM_CHANNELS(N), .DATAWIDTH_MUX_SELECTION(S),
                         .ZERO_CHANNEL0(1'b1)) dutZero (
    .CC_DECODER_READ_PORT_CLOCK_50    (clk),
    .CC_DECODER_READ_PORT_RESET_InHigh(rst),
    .bus                              (zeroBus)
  );

  assign normalBus.CC_DECODER_READ_PORT_DataBUS_In  = dataBus;
  assign normalBus.CC_DECODER_READ_PORT_SelA_In     = selA;
  assign normalBus.CC_DECODER_READ_PORT_SelB_In     = selB;
  assign normalBus.CC_DECODER_READ_PORT_ReqValid_In = reqValid;
  assign normalBus.CC_DECODER_READ_PORT_WrEnable_In = wrEnable;
  assign normalBus.CC_DECODER_READ_PORT_WrSel_In    = wrSel;
  assign normalBus.CC_DECODER_READ_PORT_WrData_In   = wrData;
  assign normalBus.CC_DECODER_READ_PORT_OutReady_In = outReady;
  assign zeroBus.CC_DECODER_READ_PORT_DataBUS_In    = dataBus;
  assign zeroBus.CC_DECODER_READ_PORT_SelA_In       = selA;
  assign zeroBus.CC_DECODER_READ_PORT_SelB_In       = selB;
  assign zeroBus.CC_DECODER_READ_PORT_ReqValid_In   = reqValid;
  assign zeroBus.CC_DECODER_READ_PORT_WrEnable_In   = wrEnable;
  assign zeroBus.CC_DECODER_READ_PORT_WrSel_In      = wrSel;
  assign zeroBus.CC_DECODER_READ_PORT_WrData_In     = wrData;
  assign zeroBus.CC_DECODER_READ_PORT_OutReady_In   = outReady;

  typedef struct {
    logic [S-1:0] selA, selB;
    logic         wrEnable;
    logic [S-1:0] wrSel;
    logic [W-1:0] wrData;
    logic [W-1:0] ch0, ch5;
    logic [W-1:0] expA, expB;
    logic         expErrA, expErrB;
    logic [W-1:0] expZA, expZB;
  } vecType;

  vecType vecs[$];
  int     checks = 0;
  int     passes = 0;

  task automatic check(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    checks++;
    if (actual === expected) passes++;
    else $display("FAIL %s: got %b, expected %b", name, actual, expected);
  endtask

  task automatic setBus(input logic [W-1:0] base);
    for (int k = 0; k < N; k++) dataBus[k*W +: W] = base + W'(k);
  endtask

  task automatic checkBoth(input string tag, input logic valid,
                           input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] za, input logic [W-1:0] zb,
                           input logic ea, input logic eb);
    checkBit({tag, " validN"}, normalBus.CC_DECODER_READ_PORT_OutValid_Out, valid);
    checkBit({tag, " validZ"}, zeroBus.CC_DECODER_READ_PORT_OutValid_Out, valid);
    check({tag, " dataA"},  normalBus.CC_DECODER_READ_PORT_DataA_Out, a);
    check({tag, " dataB"},  normalBus.CC_DECODER_READ_PORT_DataB_Out, b);
    check({tag, " dataZA"}, zeroBus.CC_DECODER_READ_PORT_DataA_Out, za);
    check({tag, " dataZB"}, zeroBus.CC_DECODER_READ_PORT_DataB_Out, zb);
    checkBit({tag, " errA"},  normalBus.CC_DECODER_READ_PORT_ErrA_Out, ea);
    checkBit({tag, " errB"},  normalBus.CC_DECODER_READ_PORT_ErrB_Out, eb);
    checkBit({tag, " errZA"}, zeroBus.CC_DECODER_READ_PORT_ErrA_Out, ea);
    checkBit({tag, " errZB"}, zeroBus.CC_DECODER_READ_PORT_ErrB_Out, eb);
  endtask

  function automatic vecType mk(input logic [S-1:0] sa, input logic [S-1:0] sb,
                                input logic we, input logic [S-1:0] ws, input logic [W-1:0] wd,
                                input logic [W-1:0] c0, input logic [W-1:0] c5,
                                input logic [W-1:0] ea, input logic [W-1:0] eb,
                                input logic era, input logic erb,
                                input logic [W-1:0] eza, input logic [W-1:0] ezb);
    vecType v;
    v.selA = sa; v.selB = sb; v.wrEnable = we; v.wrSel = ws; v.wrData = wd;
    v.ch0 = c0; v.ch5 = c5; v.expA = ea; v.expB = eb; v.expErrA = era; v.expErrB = erb;
    v.expZA = eza; v.expZB = ezb;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ea, eb;
    // Channel sweep: channel k holds A5000000+k; zero channel reads 0 on the second DUT.
    for (int k = 0; k < N; k++) begin
      ea = 32'hA500_0000 + W'(k);
      eb = 32'hA500_0000 + W'(37 - k);
      vecs.push_back(mk(S'(k), S'(37 - k), 1'b0, '0, '0, 32'hA500_0000, 32'hA500_0005,
                        ea, eb, 1'b0, 1'b0,
                        (k == 0) ? '0 : ea, (k == 37) ? '0 : eb));
    end
    vecs.push_back(mk(6'd38, 6'd63, 1'b0, '0, '0, 32'h1234_5678, 32'hA500_0005,
                      32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, '0, '0));
    vecs.push_back(mk(6'd5, 6'd5, 1'b1, 6'd5, 32'h2222, 32'hA500_0000, 32'h1111,
                      32'h2222, 32'h2222, 1'b0, 1'b0, 32'h2222, 32'h2222));
    vecs.push_back(mk(6'd5, 6'd5, 1'b1, 6'd6, 32'h2222, 32'hA500_0000, 32'h1111,
                      32'h1111, 32'h1111, 1'b0, 1'b0, 32'h1111, 32'h1111));
    vecs.push_back(mk(6'd38, 6'd0, 1'b1, 6'd38, 32'hDEAD_BEEF, 32'hA500_0000, 32'hA500_0005,
                      32'hA500_0000, 32'hA500_0000, 1'b1, 1'b0, '0, '0));
    vecs.push_back(mk(6'd0, 6'd37, 1'b1, 6'd0, 32'h7777_7777, 32'hA500_0000, 32'hA500_0005,
                      32'h7777_7777, 32'hA500_0025, 1'b0, 1'b0, '0, 32'hA500_0025));

    // Reset with a request present and the consumer stalled.
    rst = 1'b1; reqValid = 1'b1; outReady = 1'b0; wrEnable = 1'b0;
    selA = 6'd1; selB = 6'd2; wrSel = '0; wrData = '0;
    setBus(32'hA500_0000);
    repeat (2) @(posedge clk);
    #1;
    checkBoth("reset", 1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    checkBit("reset reqReady", normalBus.CC_DECODER_READ_PORT_ReqReady_Out, 1'b1);
    rst = 1'b0;

    // Back-to-back table vectors with the consumer always ready.
    outReady = 1'b1;
    reqValid = 1'b1;
    foreach (vecs[i]) begin
      setBus(32'hA500_0000);
      dataBus[0 +: W]   = vecs[i].ch0;
      dataBus[5*W +: W] = vecs[i].ch5;
      selA = vecs[i].selA; selB = vecs[i].selB;
      wrEnable = vecs[i].wrEnable; wrSel = vecs[i].wrSel; wrData = vecs[i].wrData;
      #1;
      checkBit($sformatf("vec%0d reqReady", i), normalBus.CC_DECODER_READ_PORT_ReqReady_Out, 1'b1);
      @(posedge clk); #1;
      checkBoth($sformatf("vec%0d", i), 1'b1, vecs[i].expA, vecs[i].expB,
                vecs[i].expZA, vecs[i].expZB, vecs[i].expErrA, vecs[i].expErrB);
    end

    // Delivery with no new request empties the stage; data keeps its last value.
    reqValid = 1'b0; wrEnable = 1'b0;
    @(posedge clk); #1;
    checkBoth("drain", 1'b0, 32'h7777_7777, 32'hA500_0025, '0, 32'hA500_0025, 1'b0, 1'b0);
    checkBit("drain reqReady", normalBus.CC_DECODER_READ_PORT_ReqReady_Out, 1'b1);

    // Backpressure: hold one result for four cycles while inputs churn.
    setBus(32'hA500_0000);
    selA = 6'd3; selB = 6'd4; reqValid = 1'b1;
    @(posedge clk); #1;
    checkBoth("bp accept", 1'b1, 32'hA500_0003, 32'hA500_0004, 32'hA500_0003, 32'hA500_0004, 1'b0, 1'b0);
    outReady = 1'b0;
    selA = 6'd10; selB = 6'd11;
    for (int c = 0; c < 4; c++) begin
      setBus(32'h5A00_0000 + (W'(c) << 16));
      #1;
      checkBit($sformatf("bp%0d reqReady", c), normalBus.CC_DECODER_READ_PORT_ReqReady_Out, 1'b0);
      @(posedge clk); #1;
      checkBoth($sformatf("bp%0d hold", c), 1'b1, 32'hA500_0003, 32'hA500_0004,
                32'hA500_0003, 32'hA500_0004, 1'b0, 1'b0);
    end
    setBus(32'h5A00_0000);
    outReady = 1'b1;
    #1;
    checkBit("bp release reqReady", normalBus.CC_DECODER_READ_PORT_ReqReady_Out, 1'b1);
    @(posedge clk); #1;
    checkBoth("bp release", 1'b1, 32'h5A00_000A, 32'h5A00_000B, 32'h5A00_000A, 32'h5A00_000B, 1'b0, 1'b0);

    // Reset while full with a request presented: the held result and the request are dropped.
    outReady = 1'b0; reqValid = 1'b1; selA = 6'd7; selB = 6'd8; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkBoth("midreset", 1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    checkBit("midreset reqReady", normalBus.CC_DECODER_READ_PORT_ReqReady_Out, 1'b1);
    reqValid = 1'b0; outReady = 1'b1;
    @(posedge clk); #1;
    checkBit("midreset no result", normalBus.CC_DECODER_READ_PORT_OutValid_Out, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
